// File: rtl/bwt_occ_responder.sv
`default_nettype none
// ============================================================================
// bwt_occ_responder : in-order BWT occurrence line fetcher for SMEM requests
// Rev 1.0 - initial release
// ============================================================================
module bwt_occ_responder #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 32
) (
   input  logic                          Clk_32UI,
   input  logic                          reset_BWT_extend,
   input  logic                          DRAM_valid,
   input  logic [ADDR_W-1:0]             addr_k,
   input  logic [ADDR_W-1:0]             addr_l,
   output logic                          mem_rd_en,
   output logic [ADDR_W-1:0]             mem_rd_addr,
   input  logic                          mem_rd_valid,
   input  logic [511:0]                  mem_rd_data,
   output logic                          DRAM_get,
   output logic [31:0]                   cnt_a0,
   output logic [31:0]                   cnt_a1,
   output logic [31:0]                   cnt_a2,
   output logic [31:0]                   cnt_a3,
   output logic [63:0]                   cnt_b0,
   output logic [63:0]                   cnt_b1,
   output logic [63:0]                   cnt_b2,
   output logic [63:0]                   cnt_b3,
   output logic [31:0]                   cntl_a0,
   output logic [31:0]                   cntl_a1,
   output logic [31:0]                   cntl_a2,
   output logic [31:0]                   cntl_a3,
   output logic [63:0]                   cntl_b0,
   output logic [63:0]                   cntl_b1,
   output logic [63:0]                   cntl_b2,
   output logic [63:0]                   cntl_b3,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic                          req_overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LINE_W = 384;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_K   = 3'd1,
      S_WAIT_K = 3'd2,
      S_RD_L   = 3'd3,
      S_WAIT_L = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   logic [2*ADDR_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    pending_q, pending_d;
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_k_q, cur_k_d, cur_l_q, cur_l_d;
   logic [LINE_W-1:0]   k_hold_q, k_hold_d;
   logic [LINE_W-1:0]   out_k_q, out_k_d, out_l_q, out_l_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                get_q, get_d;
   logic                ovf_q, ovf_d;
   logic                fifo_empty, fifo_full, do_push, do_pop;
   logic [2*ADDR_W-1:0] head;
   logic                unused_hi_bits;

   // Only the low 384 bits of each occurrence line carry counts.
   assign unused_hi_bits = ^mem_rd_data[511:LINE_W];

   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
      head       = fifo_mem_q[rd_ptr_q];
      do_pop     = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_RESP));
      do_push    = DRAM_valid && (!fifo_full || do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop)
         count_d = count_q - CNT_W'(1);
      ovf_d = ovf_q | (DRAM_valid & !do_push);

      state_d   = state_q;
      cur_k_d   = cur_k_q;
      cur_l_d   = cur_l_q;
      k_hold_d  = k_hold_q;
      out_k_d   = out_k_q;
      out_l_d   = out_l_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      get_d     = 1'b0;

      case (state_q)
         S_IDLE, S_RESP: begin
            if (do_pop) begin
               cur_k_d   = head[2*ADDR_W-1:ADDR_W];
               cur_l_d   = head[ADDR_W-1:0];
               rd_en_d   = 1'b1;
               rd_addr_d = head[2*ADDR_W-1:ADDR_W];
               state_d   = S_RD_K;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_K: state_d = S_WAIT_K;
         S_WAIT_K: begin
            if (mem_rd_valid) begin
               k_hold_d = mem_rd_data[LINE_W-1:0];
               // Identical k/l lines are served from a single fetch.
               if (cur_k_q == cur_l_q) begin
                  out_k_d = mem_rd_data[LINE_W-1:0];
                  out_l_d = mem_rd_data[LINE_W-1:0];
                  get_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = cur_l_q;
                  state_d   = S_RD_L;
               end
            end
         end
         S_RD_L: state_d = S_WAIT_L;
         S_WAIT_L: begin
            if (mem_rd_valid) begin
               out_k_d = k_hold_q;
               out_l_d = mem_rd_data[LINE_W-1:0];
               get_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pending_d = count_d + ((state_d != S_IDLE) ? CNT_W'(1) : CNT_W'(0));
   end

   always_ff @(posedge Clk_32UI) begin
      if (do_push)
         fifo_mem_q[wr_ptr_q] <= {addr_k, addr_l};
   end

   always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
      if (!reset_BWT_extend) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
         state_q   <= S_IDLE;
         cur_k_q   <= '0;
         cur_l_q   <= '0;
         k_hold_q  <= '0;
         out_k_q   <= '0;
         out_l_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         get_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         state_q   <= state_d;
         cur_k_q   <= cur_k_d;
         cur_l_q   <= cur_l_d;
         k_hold_q  <= k_hold_d;
         out_k_q   <= out_k_d;
         out_l_q   <= out_l_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         get_q     <= get_d;
         ovf_q     <= ovf_d;
      end
   end

   assign mem_rd_en    = rd_en_q;
   assign mem_rd_addr  = rd_addr_q;
   assign DRAM_get     = get_q;
   assign pending      = pending_q;
   assign req_overflow = ovf_q;

   assign cnt_a0  = out_k_q[31:0];
   assign cnt_a1  = out_k_q[63:32];
   assign cnt_a2  = out_k_q[95:64];
   assign cnt_a3  = out_k_q[127:96];
   assign cnt_b0  = out_k_q[191:128];
   assign cnt_b1  = out_k_q[255:192];
   assign cnt_b2  = out_k_q[319:256];
   assign cnt_b3  = out_k_q[383:320];
   assign cntl_a0 = out_l_q[31:0];
   assign cntl_a1 = out_l_q[63:32];
   assign cntl_a2 = out_l_q[95:64];
   assign cntl_a3 = out_l_q[127:96];
   assign cntl_b0 = out_l_q[191:128];
   assign cntl_b1 = out_l_q[255:192];
   assign cntl_b2 = out_l_q[319:256];
   assign cntl_b3 = out_l_q[383:320];
endmodule
`default_nettype wire

// File: tb/tb_bwt_occ_responder.sv
`default_nettype none
// ============================================================================
// tb_bwt_occ_responder : directed + randomized bench with line-memory model
// Rev 1.0 - initial release
// ============================================================================
module tb_bwt_occ_responder;
   logic        Clk_32UI = 1'b0;
   logic        reset_BWT_extend;
   logic        DRAM_valid;
   logic [31:0] addr_k, addr_l;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_valid;
   logic [511:0] mem_rd_data;
   logic        DRAM_get;
   logic [31:0] cnt_a0, cnt_a1, cnt_a2, cnt_a3, cntl_a0, cntl_a1, cntl_a2, cntl_a3;
   logic [63:0] cnt_b0, cnt_b1, cnt_b2, cnt_b3, cntl_b0, cntl_b1, cntl_b2, cntl_b3;
   logic [3:0]  pending;
   logic        req_overflow;

   bwt_occ_responder #(.FIFO_DEPTH(8), .ADDR_W(32)) dut (
      .Clk_32UI(Clk_32UI), .reset_BWT_extend(reset_BWT_extend),
      .DRAM_valid(DRAM_valid), .addr_k(addr_k), .addr_l(addr_l),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .DRAM_get(DRAM_get),
      .cnt_a0(cnt_a0), .cnt_a1(cnt_a1), .cnt_a2(cnt_a2), .cnt_a3(cnt_a3),
      .cnt_b0(cnt_b0), .cnt_b1(cnt_b1), .cnt_b2(cnt_b2), .cnt_b3(cnt_b3),
      .cntl_a0(cntl_a0), .cntl_a1(cntl_a1), .cntl_a2(cntl_a2), .cntl_a3(cntl_a3),
      .cntl_b0(cntl_b0), .cntl_b1(cntl_b1), .cntl_b2(cntl_b2), .cntl_b3(cntl_b3),
      .pending(pending), .req_overflow(req_overflow)
   );

   always #5 Clk_32UI = ~Clk_32UI;

   logic [383:0] obs_k, obs_l;
   assign obs_k = {cnt_b3, cnt_b2, cnt_b1, cnt_b0, cnt_a3, cnt_a2, cnt_a1, cnt_a0};
   assign obs_l = {cntl_b3, cntl_b2, cntl_b1, cntl_b0, cntl_a3, cntl_a2, cntl_a1, cntl_a0};

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] salt = 32'h1234_5678;
   int          mem_lat = 2;
   bit          mem_stall = 1'b0;
   bit          exp_ovf = 1'b0;
   int          pk = 0;
   logic [63:0] expq[$];
   int          rd_cyc[$];
   logic [31:0] rd_adr[$];
   int          get_cyc[$];

   always @(posedge Clk_32UI) cyc <= cyc + 1;

   function automatic logic [511:0] line_of(input logic [31:0] a, input logic [31:0] s);
      logic [511:0] v;
      for (int i = 0; i < 16; i++)
         v[32*i +: 32] = (a * 32'h9E37_79B1) ^ (s + 32'(i) * 32'h85EB_CA6B) ^ {a[15:0], 16'(i)};
      return v;
   endfunction

   // Line memory: one outstanding read, data returned mem_lat cycles after rd_en.
   bit          mem_busy = 1'b0;
   int          mem_due = 0;
   logic [31:0] mem_addr_s = '0;
   initial begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
   end
   always @(posedge Clk_32UI) begin
      #1;
      mem_rd_valid = 1'b0;
      if (mem_busy && cyc >= mem_due && !mem_stall) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = line_of(mem_addr_s, salt);
         mem_busy     = 1'b0;
      end
      if (mem_rd_en) begin
         mem_busy   = 1'b1;
         mem_due    = cyc + mem_lat;
         mem_addr_s = mem_rd_addr;
      end
   end

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic [63:0]  e;
      logic [511:0] lk, ll;
      @(negedge Clk_32UI);
      if (mem_rd_en) begin
         rd_cyc.push_back(cyc);
         rd_adr.push_back(mem_rd_addr);
      end
      if (DRAM_get) begin
         get_cyc.push_back(cyc);
         chk("get_has_request", 384'(expq.size() != 0), 384'(1));
         if (expq.size() != 0) begin
            e  = expq.pop_front();
            lk = line_of(e[63:32], salt);
            ll = line_of(e[31:0], salt);
            chk("resp_k_line", obs_k, lk[383:0]);
            chk("resp_l_line", obs_l, ll[383:0]);
         end
      end
      chk("pending", 384'(pending), 384'(expq.size() + int'(DRAM_get)));
      chk("overflow", 384'(req_overflow), 384'(exp_ovf));
      if (int'(pending) > pk) pk = int'(pending);
   endtask

   task automatic issue(input logic [31:0] k, input logic [31:0] l, input bit acc);
      DRAM_valid = 1'b1;
      addr_k     = k;
      addr_l     = l;
      if (acc) expq.push_back({k, l});
      tick();
      DRAM_valid = 1'b0;
   endtask

   task automatic clr();
      rd_cyc.delete();
      rd_adr.delete();
      get_cyc.delete();
      pk = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int          t0;
      logic [511:0] lk, ll;
      logic [31:0] rk, rl;
      bit          sent;

      reset_BWT_extend = 1'b0;
      DRAM_valid = 1'b0;
      addr_k = '0;
      addr_l = '0;
      repeat (3) @(negedge Clk_32UI);
      chk("rst_k_bus", obs_k, '0);
      chk("rst_l_bus", obs_l, '0);
      chk("rst_get", 384'(DRAM_get), '0);
      chk("rst_rd_en", 384'(mem_rd_en), '0);
      chk("rst_rd_addr", 384'(mem_rd_addr), '0);
      chk("rst_pending", 384'(pending), '0);
      reset_BWT_extend = 1'b1;
      idle(2);

      // Single request, L=2
      clr();
      salt = 32'hA5A5_0001;
      issue(32'h10, 32'h20, 1'b1);
      t0 = cyc;
      idle(12);
      chk("single_rd_count", 384'(rd_cyc.size()), 384'(2));
      if (rd_cyc.size() == 2) begin
         chk("single_rd_k_cyc", 384'(rd_cyc[0] - t0), 384'(1));
         chk("single_rd_k_adr", 384'(rd_adr[0]), 384'(32'h10));
         chk("single_rd_l_cyc", 384'(rd_cyc[1] - t0), 384'(4));
         chk("single_rd_l_adr", 384'(rd_adr[1]), 384'(32'h20));
      end
      chk("single_get_count", 384'(get_cyc.size()), 384'(1));
      if (get_cyc.size() == 1) chk("single_get_cyc", 384'(get_cyc[0] - t0), 384'(7));
      lk = line_of(32'h10, salt);
      ll = line_of(32'h20, salt);
      chk("single_cnt_a0_hold", 384'(cnt_a0), 384'(lk[31:0]));
      chk("single_cntl_b3_hold", 384'(cntl_b3), 384'(ll[383:320]));

      // Same-line request
      clr();
      issue(32'h55, 32'h55, 1'b1);
      t0 = cyc;
      idle(10);
      chk("same_rd_count", 384'(rd_cyc.size()), 384'(1));
      chk("same_get_count", 384'(get_cyc.size()), 384'(1));
      if (get_cyc.size() == 1) chk("same_get_cyc", 384'(get_cyc[0] - t0), 384'(4));
      chk("same_k_eq_l", obs_k, obs_l);

      // Three back-to-back requests
      clr();
      salt = 32'h0BAD_F00D;
      issue(32'h100, 32'h200, 1'b1);
      t0 = cyc;
      issue(32'h101, 32'h201, 1'b1);
      issue(32'h102, 32'h202, 1'b1);
      idle(30);
      chk("b2b_pending_peak", 384'(pk), 384'(3));
      chk("b2b_get_count", 384'(get_cyc.size()), 384'(3));
      for (int i = 0; i < 3 && i < get_cyc.size(); i++)
         chk("b2b_get_cyc", 384'(get_cyc[i] - t0), 384'(7 * (i + 1)));

      // Stalled memory, 10 requests into a depth-8 queue
      clr();
      mem_stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 9) exp_ovf = 1'b1;
         issue(32'h300 + 32'(i), 32'h400 + 32'(i), i < 9);
      end
      chk("stall_pending_full", 384'(pending), 384'(9));
      chk("stall_overflow", 384'(req_overflow), 384'(1));
      mem_stall = 1'b0;
      idle(100);
      chk("stall_get_count", 384'(get_cyc.size()), 384'(9));

      // Reset while in WAIT_L with two requests queued
      clr();
      issue(32'h500, 32'h600, 1'b1);
      issue(32'h501, 32'h601, 1'b1);
      issue(32'h502, 32'h602, 1'b1);
      idle(3);
      chk("rst_mid_pending_before", 384'(pending), 384'(3));
      reset_BWT_extend = 1'b0;
      #1;
      chk("rst_mid_k_bus", obs_k, '0);
      chk("rst_mid_l_bus", obs_l, '0);
      chk("rst_mid_pending", 384'(pending), '0);
      chk("rst_mid_overflow", 384'(req_overflow), '0);
      #1;
      reset_BWT_extend = 1'b1;
      expq.delete();
      exp_ovf = 1'b0;
      clr();
      idle(20);
      chk("rst_mid_no_get", 384'(get_cyc.size()), '0);
      chk("rst_mid_no_read", 384'(rd_cyc.size()), '0);

      // Push coinciding with pop while the queue is full
      clr();
      mem_stall = 1'b1;
      for (int i = 0; i < 9; i++) issue(32'h700 + 32'(i), 32'h800 + 32'(i), 1'b1);
      mem_stall = 1'b0;
      sent = 1'b0;
      for (int i = 0; i < 110; i++) begin
         if (DRAM_get && !sent) begin
            sent = 1'b1;
            issue(32'h7FF, 32'h8FF, 1'b1);
         end else begin
            tick();
         end
      end
      chk("fullpop_sent", 384'(sent), 384'(1));
      chk("fullpop_get_count", 384'(get_cyc.size()), 384'(10));
      chk("fullpop_overflow", 384'(req_overflow), '0);

      // Randomized traffic
      clr();
      salt = $urandom;
      for (int n = 0; n < 25; n++) begin
         idle($urandom_range(0, 6));
         while (expq.size() > 8) tick();
         mem_lat = $urandom_range(1, 4);
         rk = $urandom_range(0, 63);
         rl = ($urandom_range(0, 3) == 0) ? rk : 32'($urandom_range(0, 63));
         issue(rk, rl, 1'b1);
      end
      idle(300);
      chk("rand_get_count", 384'(get_cyc.size()), 384'(25));
      chk("rand_drained", 384'(expq.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/bwt_occ_responder.md
Name: bwt_occ_responder

Overview:
- Memory-side responder for the SMEM pipeline's BWT occurrence lookups.
- Accepts the pipeline's request pair (DRAM_valid, addr_k, addr_l) and queues it. Fetches the two occurrence lines from a 512-bit line memory port and returns them on DRAM_get plus the cnt_*/cntl_* buses.
- Responses return strictly in request order.
- Sits between the extension pipeline's request outputs and the off-chip memory controller.

Parameters:
- FIFO_DEPTH, 8, request queue entries (power of 2, >=2)
- ADDR_W, 32, width of addr_k/addr_l and mem_rd_addr

Ports:
- Clk_32UI  input  1  clock, all logic rising-edge
- reset_BWT_extend  input  1  asynchronous active-low reset
- DRAM_valid  input  1  request strobe, one request per asserted cycle
- addr_k  input  ADDR_W  line address for k interval
- addr_l  input  ADDR_W  line address for l interval
- mem_rd_en  output  1  one-cycle read strobe to memory
- mem_rd_addr  output  ADDR_W  read line address, valid with mem_rd_en
- mem_rd_valid  input  1  read data valid
- mem_rd_data  input  512  read line
- DRAM_get  output  1  one-cycle response strobe
- cnt_a0..cnt_a3  output  32 each  k-line fields
- cnt_b0..cnt_b3  output  64 each  k-line fields
- cntl_a0..cntl_a3  output  32 each  l-line fields
- cntl_b0..cntl_b3  output  64 each  l-line fields
- pending  output  $clog2(FIFO_DEPTH)+1  queued plus in-service requests
- req_overflow  output  1  sticky: request dropped because the FIFO was full

Behaviour:
- Reset (async, while reset_BWT_extend=0):
  - All outputs 0; FIFO empty; FSM in IDLE; req_overflow cleared.
  - Reset mid-operation discards queued and in-flight requests.
  - mem_rd_valid arriving in IDLE is ignored.
- Enqueue:
  - On each edge with DRAM_valid=1, push {addr_k, addr_l} if not full.
  - If full, drop the request and set req_overflow (cleared only by reset).
  - Push and pop in the same cycle are both honoured; a push when full is accepted if a pop occurs that same edge.
- Line field mapping (same mapping for the l line onto cntl_*):
  - cnt_a0=[31:0], cnt_a1=[63:32], cnt_a2=[95:64], cnt_a3=[127:96]
  - cnt_b0=[191:128], cnt_b1=[255:192], cnt_b2=[319:256], cnt_b3=[383:320]
  - Bits [511:384] are ignored.
- FSM states: IDLE, RD_K, WAIT_K, RD_L, WAIT_L, RESP. At most one memory read outstanding.
  - IDLE: FIFO non-empty -> pop head into working registers -> RD_K.
  - RD_K: assert mem_rd_en=1 with mem_rd_addr=addr_k for exactly 1 cycle -> WAIT_K.
  - WAIT_K, on mem_rd_valid: capture line into the k holding register.
    - addr_k==addr_l: also capture into the l register -> RESP.
    - Otherwise -> RD_L.
  - RD_L: mem_rd_en with addr_l for 1 cycle -> WAIT_L.
  - WAIT_L, on mem_rd_valid: capture l line -> RESP.
  - RESP: DRAM_get=1 for 1 cycle; cnt_*/cntl_* driven from holding registers.
    - FIFO non-empty -> pop -> RD_K.
    - Otherwise -> IDLE.
- Data outputs hold their last response value until the next RESP, including while DRAM_get=0.
- Latency: with request sampled at edge 0 and memory latency L (valid L cycles after rd_en), all on an idle block:
  - mem_rd_en(k) in cycle 1
  - mem_rd_en(l) in cycle 2+L
  - DRAM_get in cycle 3+2L
  - Same-line requests: DRAM_get in cycle 2+L.
- Throughput: back-to-back requests are serviced serially; the next RD_K immediately follows RESP.
- pending = FIFO count + (FSM != IDLE ? 1 : 0). It is 0 in IDLE with an empty FIFO.

Test Plan:
- Single request, memory model L=2, addr_k=0x10, addr_l=0x20, lines hold distinct patterns:
  - mem_rd_en at cycles 1 (addr 0x10) and 4 (addr 0x20); DRAM_get at cycle 7.
  - cnt_a0 = k line[31:0], cntl_b3 = l line[383:320].
- Same-line request addr_k=addr_l=0x55, L=2:
  - Exactly one mem_rd_en; DRAM_get at cycle 4; cnt_* equal cntl_*.
- Three back-to-back requests (DRAM_valid high 3 cycles), L=2:
  - pending peaks at 3; three DRAM_get pulses in order, 7 cycles apart.
  - Each response carries its own k/l lines; req_overflow=0.
- FIFO_DEPTH=8, memory stalled (no mem_rd_valid), 10 consecutive requests:
  - First 9 are held (1 in service + 8 queued); req_overflow=1 after the 10th.
  - After releasing memory, exactly 9 DRAM_get pulses.
- Reset asserted while in WAIT_L with 2 requests queued:
  - Outputs 0 immediately; pending=0.
  - A late mem_rd_valid is ignored; no DRAM_get follows.
- Push and pop on the same edge with the FIFO full:
  - Request accepted; req_overflow stays 0; order preserved.
